// File: rtl/imm_decode_buf.sv
// Immediate decoder feeding a DEPTH-entry FIFO between fetch and execute; push-to-head latency 1 cycle, no bypass.
// Backpressure: in_ready low while full or in reset; head fields hold steady while out_ready is low.

module imm_decode_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign push_rdy = (count != FULL) & ~rst;
  assign pop_vld  = (count != '0);
  assign push     = push_vld & push_rdy;
  assign pop      = pop_vld & pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  // flush outranks any push/pop in the same cycle; storage is only cleared by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module imm_decode_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_t;

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_type_t       imm_type;
    logic            illegal;
  } entry_t;

  logic [4:0]         op;
  imm_type_t          dec_type;
  logic               dec_illegal;
  logic signed [31:0] imm32;
  entry_t             in_entry;
  entry_t             head;

  assign op = in_ins[6:2];

  always_comb begin
    dec_type    = IMM_NONE;
    dec_illegal = 1'b0;
    case (op)
      5'b00000, 5'b00100, 5'b00110, 5'b00011, 5'b11001: dec_type = IMM_I;
      5'b01000: dec_type = IMM_S;
      5'b11000: dec_type = IMM_B;
      5'b01101, 5'b00101: dec_type = IMM_U;
      5'b11011: dec_type = IMM_J;
      5'b11100: dec_type = in_ins[14] ? IMM_Z : IMM_I;
      5'b01100, 5'b01110: dec_type = IMM_NONE;
      default: dec_illegal = 1'b1;
    endcase
    if (in_ins[1:0] != 2'b11) dec_illegal = 1'b1;
    if (dec_illegal) dec_type = IMM_NONE;
  end

  // Z has bit 31 clear and NONE is all ones, so one signed widening covers every type
  always_comb begin
    imm32 = '1;
    case (dec_type)
      IMM_I:   imm32 = {{20{in_ins[31]}}, in_ins[31:20]};
      IMM_S:   imm32 = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
      IMM_B:   imm32 = {{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
      IMM_U:   imm32 = {in_ins[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
      IMM_Z:   imm32 = {27'b0, in_ins[19:15]};
      default: imm32 = '1;
    endcase
  end

  always_comb begin
    in_entry          = '0;
    in_entry.ins      = in_ins;
    in_entry.pc       = in_pc;
    in_entry.imm      = XLEN'(imm32);
    in_entry.imm_type = dec_type;
    in_entry.illegal  = dec_illegal;
  end

  imm_decode_buf_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (in_entry),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head)
  );

  assign out_ins      = head.ins;
  assign out_pc       = head.pc;
  assign out_imm      = head.imm;
  assign out_imm_type = head.imm_type;
  assign out_illegal  = head.illegal;
endmodule

// File: tb/tb_imm_decode_buf.sv
// Drives an XLEN=32 and an XLEN=64 instance in lockstep and checks both against tables and a queue model.
module tb_imm_decode_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_ins;
  logic [63:0] in_pc;

  logic        r32, v32, ill32;
  logic [31:0] ins32, pc32, imm32;
  logic [2:0]  typ32;
  logic        r64, v64, ill64;
  logic [31:0] ins64;
  logic [63:0] pc64, imm64;
  logic [2:0]  typ64;

  imm_decode_buf #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_ins(in_ins), .in_pc(in_pc[31:0]),
    .out_valid(v32), .out_ready(out_ready), .out_ins(ins32), .out_pc(pc32),
    .out_imm(imm32), .out_imm_type(typ32), .out_illegal(ill32));

  imm_decode_buf #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(v64), .out_ready(out_ready), .out_ins(ins64), .out_pc(pc64),
    .out_imm(imm64), .out_imm_type(typ64), .out_illegal(ill64));

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [2:0]  typ;
    logic        ill;
    logic [63:0] imm;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  typ;
    logic        ill;
    logic [63:0] imm;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  exp_t e, ea, eb, ec;
  exp_t q [$];
  int   checks = 0;
  int   errors = 0;
  int   ops [16] = '{0, 3, 4, 5, 6, 8, 12, 13, 14, 24, 25, 27, 28, 1, 2, 31};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input exp_t x);
    chk({tag, " valid32"}, v32, 1'b1);
    chk({tag, " valid64"}, v64, 1'b1);
    chk({tag, " ins32"}, ins32, x.ins);
    chk({tag, " ins64"}, ins64, x.ins);
    chk({tag, " pc32"}, pc32, x.pc[31:0]);
    chk({tag, " pc64"}, pc64, x.pc);
    chk({tag, " type32"}, typ32, x.typ);
    chk({tag, " type64"}, typ64, x.typ);
    chk({tag, " illegal32"}, ill32, x.ill);
    chk({tag, " illegal64"}, ill64, x.ill);
    chk({tag, " imm32"}, imm32, x.imm[31:0]);
    chk({tag, " imm64"}, imm64, x.imm);
  endtask

  // Two's-complement interpretation of a bits-wide field value.
  function automatic longint sx(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
    exp_t   r;
    int     op;
    longint v;
    op    = int'(ins[6:2]);
    r.ins = ins;
    r.pc  = pc;
    r.ill = 1'b0;
    r.typ = 3'd0;
    case (op)
      0, 3, 4, 6, 25: r.typ = 3'd1;
      8:              r.typ = 3'd2;
      24:             r.typ = 3'd3;
      5, 13:          r.typ = 3'd4;
      27:             r.typ = 3'd5;
      28:             r.typ = ins[14] ? 3'd6 : 3'd1;
      12, 14:         r.typ = 3'd0;
      default:        r.ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) r.ill = 1'b1;
    if (r.ill) r.typ = 3'd0;
    case (r.typ)
      3'd1: v = sx(longint'(ins[31:20]), 12);
      3'd2: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      3'd3: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                   + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      3'd4: v = sx(longint'(ins[31:12]) * 4096, 32);
      3'd5: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                   + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd6: v = longint'(ins[19:15]);
      default: v = -1;
    endcase
    r.imm = 64'(v);
    return r;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    w      = $urandom;
    w[6:2] = 5'(ops[$urandom_range(0, 15)]);
    w[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
    return w;
  endfunction

  function automatic exp_t from_vec(input vec_t v, input logic [63:0] pc);
    exp_t r;
    r.ins = v.ins;
    r.pc  = pc;
    r.typ = v.typ;
    r.ill = v.ill;
    r.imm = v.imm;
    return r;
  endfunction

  task automatic offer(input exp_t x);
    in_valid = 1'b1;
    in_ins   = x.ins;
    in_pc    = x.pc;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1]  = '{32'hFE112E23, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[2]  = '{32'hFF9FF06F, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[3]  = '{32'h800002B7, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000};
    vecs[4]  = '{32'h3002D073, 3'd6, 1'b0, 64'h0000_0000_0000_0005};
    vecs[5]  = '{32'h00000000, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6]  = '{32'h00000033, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[7]  = '{32'hFE000EE3, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[8]  = '{32'h00500093, 3'd1, 1'b0, 64'h0000_0000_0000_0005};
    vecs[9]  = '{32'h00500090, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{32'h00000073, 3'd1, 1'b0, 64'h0000_0000_0000_0000};
    vecs[11] = '{32'h12345297, 3'd4, 1'b0, 64'h0000_0000_1234_5000};
    vecs[12] = '{32'h30002573, 3'd1, 1'b0, 64'h0000_0000_0000_0300};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ins = '0; in_pc = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready32", r32, 1'b0);
    chk("rst in_ready64", r64, 1'b0);
    chk("rst valid32", v32, 1'b0);
    chk("rst valid64", v64, 1'b0);
    chk("rst ins64", ins64, 0);
    chk("rst pc64", pc64, 0);
    chk("rst imm32", imm32, 0);
    chk("rst imm64", imm64, 0);
    chk("rst type64", typ64, 0);
    chk("rst illegal64", ill64, 0);
    rst = 1'b0;
    #1;
    chk("release in_ready32", r32, 1'b1);
    chk("release in_ready64", r64, 1'b1);

    for (int i = 0; i < NV; i++) begin
      e = from_vec(vecs[i], {$urandom, $urandom});
      offer(e);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check_head($sformatf("vec%0d", i), e);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("vec%0d drained", i), v64, 1'b0);
    end

    ea = from_vec(vecs[1], 64'h0000_0000_0000_1000);
    eb = from_vec(vecs[2], 64'h0000_0000_0000_1004);
    out_ready = 1'b1;
    offer(ea);
    @(negedge clk);
    offer(eb);
    check_head("b2b sw", ea);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("b2b jal", eb);
    @(negedge clk);
    chk("b2b empty", v64, 1'b0);
    out_ready = 1'b0;

    ea = from_vec(vecs[0], 64'h10);
    eb = from_vec(vecs[7], 64'h14);
    ec = from_vec(vecs[8], 64'h18);
    offer(ea);
    chk("full rdy0", r64, 1'b1);
    @(negedge clk);
    offer(eb);
    chk("full rdy1", r32, 1'b1);
    check_head("full first", ea);
    @(negedge clk);
    offer(ec);
    chk("full rdy32 low", r32, 1'b0);
    chk("full rdy64 low", r64, 1'b0);
    @(negedge clk);
    chk("full held rdy", r64, 1'b0);
    check_head("full stable", ea);
    out_ready = 1'b1;
    @(negedge clk);
    chk("after pop rdy", r64, 1'b1);
    check_head("drain second", eb);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("drain third", ec);
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain empty", v64, 1'b0);

    offer(ea);
    @(negedge clk);
    offer(eb);
    @(negedge clk);
    offer(ec);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush valid32", v32, 1'b0);
    chk("flush valid64", v64, 1'b0);
    chk("flush rdy64", r64, 1'b1);
    @(negedge clk);
    chk("flush discarded", v64, 1'b0);
    offer(ea);
    @(negedge clk);
    offer(eb);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush push discarded", v32, 1'b0);
    offer(ec);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("post flush head", ec);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post flush empty", v64, 1'b0);

    offer(ea);
    @(negedge clk);
    offer(eb);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst valid32", v32, 1'b0);
    chk("midrst valid64", v64, 1'b0);
    chk("midrst rdy32", r32, 1'b0);
    chk("midrst rdy64", r64, 1'b0);
    chk("midrst ins64", ins64, 0);
    @(negedge clk);
    chk("midrst rdy held", r64, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst release rdy", r64, 1'b1);
    chk("midrst release valid", v64, 1'b0);

    q.delete();
    for (int c = 0; c < 3000; c++) begin
      bit do_push, do_pop;
      @(negedge clk);
      chk("rnd valid32", v32, q.size() != 0);
      chk("rnd valid64", v64, q.size() != 0);
      chk("rnd rdy32", r32, q.size() != 2);
      chk("rnd rdy64", r64, q.size() != 2);
      if (q.size() != 0) check_head("rnd head", q[0]);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_ins    = rand_ins();
      in_pc     = {$urandom, $urandom};
      if (flush) begin
        q.delete();
      end else begin
        do_push = in_valid && (q.size() != 2);
        do_pop  = out_ready && (q.size() != 0);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(ref_decode(in_ins, in_pc));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_decode_buf.md
# imm_decode_buf

Buffered, parametrised immediate decoder sitting between instruction fetch and the execute stage. Accepts one instruction word (with its PC tag) per cycle over a valid/ready handshake. Classifies the opcode, including J-type, CSR zimm and illegal-opcode detection, and builds an XLEN-wide immediate. Results are stored in a DEPTH-entry FIFO so fetch and execute can stall independently.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; a power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  input entry offered.
- in_ready  out  1  buffer can accept an entry.
- in_ins  in  32  instruction word.
- in_pc  in  XLEN  PC tag, passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_ins  out  32  head instruction word.
- out_pc  out  XLEN  head PC tag.
- out_imm  out  XLEN  head immediate.
- out_imm_type  out  3  encoding: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
- out_illegal  out  1  head opcode is unrecognised.

## Operation
- Decode is combinational on in_ins; the result is written into the FIFO with in_ins and in_pc on a push.
- Opcode classification uses op = in_ins[6:2]:
  - LOAD 00000, OP_IMM 00100, OP_IMM_32 00110, MISC_MEM 00011, JALR 11001 -> I.
  - STORE 01000 -> S; BRANCH 11000 -> B.
  - LUI 01101, AUIPC 00101 -> U.
  - JAL 11011 -> J.
  - SYSTEM 11100 -> Z if in_ins[14]=1, else I.
  - OP 01100, OP_32 01110 -> NONE, not illegal.
- Illegal: in_ins[1:0] != 2'b11, or op not in the list above. Sets illegal=1 and type NONE.
- Immediates are built from RV32 bit fields, then sign-extended from in_ins[31] to XLEN:
  - I: ins[31:20].
  - S: {ins[31:25], ins[11:7]}.
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U: {ins[31:12], 12'b0}; sign-extended when XLEN=64.
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
- Z: ins[19:15], zero-extended.
- NONE (including illegal): all ones.
- FIFO:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - in_ready = (count != DEPTH) & !rst.
  - out_valid = (count != 0).
  - Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any non-full, non-empty occupancy. When full, no push occurs; when empty, no pop occurs.
- No combinational bypass: an input never appears on out_* in the same cycle.
- flush:
  - Next cycle count=0 and pointers=0.
  - A push or pop coinciding with flush is discarded.
  - Takes priority over everything except rst.

## Timing
- Reset values:
  - count and pointers 0; out_valid 0.
  - in_ready 0 while rst is asserted, 1 the first cycle after release.
  - Storage cleared to 0, so out_ins, out_pc and out_imm read 0, out_imm_type reads 0 (NONE) and out_illegal reads 0.
- Latency: push in cycle N -> out_valid=1 and decoded fields on out_* in cycle N+1 if the FIFO was empty.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- Full with out_ready=0: in_ready drops in the cycle after the DEPTH-th push. A pop in cycle N makes in_ready=1 in N+1.
- out_* are stable while out_valid=1 and out_ready=0.
- rst asserted mid-stream: all entries lost immediately, regardless of clk.

## Test plan
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) into an empty buffer -> next cycle out_valid=1, type 1, imm 0xFFFFFFFF, illegal 0.
- Push 0xFE112E23 (sw) then 0xFF9FF06F (jal x0,-8) back-to-back with out_ready=1 -> heads are type 2 / imm 0xFFFFFFFC, then type 5 / imm 0xFFFFFFF8, on consecutive cycles.
- XLEN=64:
  - Push 0x800002B7 (lui x5,0x80000) -> type 4, imm 0xFFFFFFFF80000000.
  - Push 0x3002D073 (csrrwi) -> type 6, imm 5.
- Push 0x00000000 -> illegal 1, type 0, imm all ones. Push 0x00000033 (add) -> type 0, illegal 0.
- DEPTH=2, out_ready=0, in_valid held for 3 inputs:
  - in_ready=0 after the 2nd push; the 3rd is held.
  - Raise out_ready -> entries drain in order and the 3rd is accepted.
- Fill 2 entries, then assert flush with in_valid=1 -> next cycle out_valid=0, count 0, the input is discarded. Then assert rst mid-stream -> out_valid=0 immediately and in_ready=0 until release.
